auto_player: RTL and testbench

- Automated opponent that plays the player-2 side of the tic-tac-toe board.
- Reads the per-player cell occupancy and the turn indicator from the game core.
- Chooses a move: win first, then block, then centre, then corner, then edge.
- Drives the game's cell button inputs with a one-hot press pulse, then waits for the core to acknowledge the move. It sits between the board state outputs and the button inputs, in place of a human player 2.

---
 rtl/auto_player.sv | 166 ++++++++++++++++
 tb/tb_auto_player.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/auto_player.sv
// Automated player-2 opponent for tic-tac-toe: scans for a win, then a block,
// then takes a positional pick, presses the chosen cell button and waits for the ack.
module auto_player #(
    parameter int PRESS_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       p2_turn,
    input  logic       game_over,
    input  logic [8:0] p1_cells,
    input  logic [8:0] p2_cells,
    output logic [8:0] btn,
    output logic       busy,
    output logic [3:0] move_idx,
    output logic       ack_err
);

    typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, PICK, PRESS, WAIT_ACK} state_t;

    localparam int TMAX = (PRESS_CYCLES > ACK_TIMEOUT) ? PRESS_CYCLES : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    // Positional preference, first entry in the low nibble: 4,0,2,6,8,1,3,5,7.
    localparam logic [35:0] PICK_ORDER = {4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};

    state_t        state;
    logic [2:0]    line;
    logic [TW-1:0] timer;
    logic          armed;

    logic [8:0] occ, free, mask;
    logic [3:0] ca, cb, cc;
    logic       hit;
    logic [3:0] hit_idx;
    logic       pick_ok;
    logic [3:0] pick_idx;

    function automatic logic [11:0] line_cells(input logic [2:0] l);
        case (l)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    assign occ  = p1_cells | p2_cells;
    assign free = ~occ;
    assign mask = (state == SCAN_WIN) ? p2_cells : p1_cells;

    always_comb begin
        {ca, cb, cc} = line_cells(line);
        hit     = 1'b0;
        hit_idx = '0;
        if (mask[ca] && mask[cb] && free[cc]) begin
            hit     = 1'b1;
            hit_idx = cc;
        end else if (mask[ca] && free[cb] && mask[cc]) begin
            hit     = 1'b1;
            hit_idx = cb;
        end else if (free[ca] && mask[cb] && mask[cc]) begin
            hit     = 1'b1;
            hit_idx = ca;
        end
    end

    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (!pick_ok && free[PICK_ORDER[i*4 +: 4]]) begin
                pick_ok  = 1'b1;
                pick_idx = PICK_ORDER[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            line     <= '0;
            timer    <= '0;
            btn      <= '0;
            busy     <= 1'b0;
            move_idx <= '0;
            ack_err  <= 1'b0;
            armed    <= 1'b1;
        end else if (state != IDLE && (game_over || !enable)) begin
            state <= IDLE;
            btn   <= '0;
            busy  <= 1'b0;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A finished turn must see p2_turn low before another turn may start.
                    if (!p2_turn)
                        armed <= 1'b1;
                    if (enable && p2_turn && !game_over && armed) begin
                        state <= SCAN_WIN;
                        line  <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN_WIN, SCAN_BLOCK: begin
                    if (hit) begin
                        move_idx <= hit_idx;
                        timer    <= '0;
                        state    <= PRESS;
                    end else if (line == 3'd7) begin
                        line  <= '0;
                        state <= (state == SCAN_WIN) ? SCAN_BLOCK : PICK;
                    end else begin
                        line <= line + 3'd1;
                    end
                end
                PICK: begin
                    if (pick_ok) begin
                        move_idx <= pick_idx;
                        timer    <= '0;
                        state    <= PRESS;
                    end else begin
                        ack_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                PRESS: begin
                    if (timer == '0) begin
                        btn   <= 9'd1 << move_idx;
                        timer <= TW'(1);
                    end else if (timer == TW'(PRESS_CYCLES)) begin
                        btn   <= '0;
                        timer <= '0;
                        state <= WAIT_ACK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (occ[move_idx] || !p2_turn) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        armed <= 1'b0;
                        timer <= '0;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        ack_err <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        armed   <= 1'b0;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// Scoreboard bench for auto_player: expected presses are queued when a turn is
// started and compared when the press appears on btn.
module tb_auto_player;

    logic       clk = 1'b0;
    logic       reset_n, enable, p2_turn, game_over;
    logic [8:0] p1_cells, p2_cells;
    logic [8:0] btn;
    logic       busy;
    logic [3:0] move_idx;
    logic       ack_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0] btn;
        logic [3:0] idx;
        int         lat;
    } exp_t;
    exp_t exp_q[$];

    // Move table: board, expected button, index and latency from the trigger edge.
    logic [8:0] t_p1  [6] = '{9'h001, 9'h018, 9'h003, 9'h001, 9'h110, 9'h050};
    logic [8:0] t_p2  [6] = '{9'h000, 9'h003, 9'h018, 9'h044, 9'h001, 9'h001};
    logic [8:0] t_btn [6] = '{9'h010, 9'h004, 9'h020, 9'h010, 9'h004, 9'h004};
    logic [3:0] t_idx [6] = '{4'd4, 4'd2, 4'd5, 4'd4, 4'd2, 4'd2};
    int         t_lat [6] = '{18, 2, 3, 9, 18, 17};

    always #5 clk = ~clk;

    auto_player #(
        .PRESS_CYCLES(2),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .p2_turn  (p2_turn),
        .game_over(game_over),
        .p1_cells (p1_cells),
        .p2_cells (p2_cells),
        .btn      (btn),
        .busy     (busy),
        .move_idx (move_idx),
        .ack_err  (ack_err)
    );

    // Waits (bounded) for a press and measures its latency and width; lat=-1 if none.
    task automatic capture(output logic [8:0] b, output logic [3:0] idx,
                           output int lat, output int width);
        int n = 0;
        lat = -1; width = 0; b = '0; idx = '0;
        while (lat < 0 && n < 40) begin
            @(posedge clk); n++; #1;
            if (btn !== 9'h000) begin
                lat = n - 1; b = btn; idx = move_idx;
            end
        end
        if (lat >= 0) begin
            width = 1;
            while (width < 20) begin
                @(posedge clk); #1;
                if (btn === b) width++;
                else break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; enable = 1'b1; p2_turn = 1'b0; game_over = 1'b0;
        p1_cells = '0; p2_cells = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (btn !== 9'h000) begin failures++; $display("FAIL reset_btn got=%h exp=000", btn); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (move_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", move_idx); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ack_err); end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_moves;
        logic [8:0] b;
        logic [3:0] idx;
        int lat, w;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            p1_cells = t_p1[i]; p2_cells = t_p2[i]; p2_turn = 1'b1;
            e.btn = t_btn[i]; e.idx = t_idx[i]; e.lat = t_lat[i];
            exp_q.push_back(e);
            capture(b, idx, lat, w);
            e = exp_q.pop_front();
            checks++; if (b !== e.btn) begin failures++; $display("FAIL move%0d_btn got=%h exp=%h", i, b, e.btn); end
            checks++; if (idx !== e.idx) begin failures++; $display("FAIL move%0d_idx got=%0d exp=%0d", i, idx, e.idx); end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL move%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (w != 2) begin failures++; $display("FAIL move%0d_width got=%0d exp=2", i, w); end
            // Acknowledge through occupancy while p2_turn stays high.
            @(negedge clk) p2_cells = p2_cells | e.btn;
            @(posedge clk); #1;
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL move%0d_ack_busy got=%b exp=0", i, busy); end
            checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL move%0d_err got=%b exp=0", i, ack_err); end
            @(negedge clk) p2_turn = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_game_over;
        int n = 0;
        logic [8:0] b = '0;
        exp_t e;
        @(negedge clk);
        p1_cells = 9'h001; p2_cells = 9'h000; p2_turn = 1'b1;
        e.btn = 9'h010; e.idx = 4'd4; e.lat = 18;
        exp_q.push_back(e);
        while (b === 9'h000 && n < 40) begin
            @(posedge clk); n++; #1;
            b = btn;
        end
        e = exp_q.pop_front();
        checks++; if (b !== e.btn) begin failures++; $display("FAIL abort_press got=%h exp=%h", b, e.btn); end
        @(negedge clk) game_over = 1'b1;
        @(posedge clk); #1;
        checks++; if (btn !== 9'h000) begin failures++; $display("FAIL abort_btn got=%h exp=000", btn); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", ack_err); end
        checks++; if (move_idx !== e.idx) begin failures++; $display("FAIL abort_idx got=%0d exp=%0d", move_idx, e.idx); end
        @(negedge clk) begin game_over = 1'b0; p2_turn = 1'b0; end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        logic [8:0] b;
        logic [3:0] idx;
        int lat, w;
        int spurious = 0;
        exp_t e;
        @(negedge clk);
        p1_cells = 9'h001; p2_cells = 9'h000; p2_turn = 1'b1;
        e.btn = 9'h010; e.idx = 4'd4; e.lat = 18;
        exp_q.push_back(e);
        capture(b, idx, lat, w);
        e = exp_q.pop_front();
        checks++; if (b !== e.btn) begin failures++; $display("FAIL timeout_btn got=%h exp=%h", b, e.btn); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, e.lat); end
        repeat (15) @(posedge clk);
        #1;
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL timeout_early_err got=%b exp=0", ack_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_wait_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", ack_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        repeat (25) begin
            @(posedge clk); #1;
            if (btn !== 9'h000 || busy !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin failures++; $display("FAIL retrigger_hold got=%0d exp=0", spurious); end
        @(negedge clk) p2_turn = 1'b0;
        @(negedge clk) p2_turn = 1'b1;
        e.btn = 9'h010; e.idx = 4'd4; e.lat = 18;
        exp_q.push_back(e);
        capture(b, idx, lat, w);
        e = exp_q.pop_front();
        checks++; if (b !== e.btn) begin failures++; $display("FAIL retrigger_btn got=%h exp=%h", b, e.btn); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL retrigger_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL sticky_err got=%b exp=1", ack_err); end
        @(negedge clk) p2_turn = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL retrigger_ack_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_scan;
        logic [8:0] b;
        logic [3:0] idx;
        int lat, w;
        exp_t e;
        @(negedge clk);
        p1_cells = 9'h001; p2_cells = 9'h000; p2_turn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midscan_busy got=%b exp=1", busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (btn !== 9'h000) begin failures++; $display("FAIL async_btn got=%h exp=000", btn); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy); end
        checks++; if (move_idx !== 4'd0) begin failures++; $display("FAIL async_idx got=%0d exp=0", move_idx); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL async_err got=%b exp=0", ack_err); end
        @(negedge clk) reset_n = 1'b1;
        e.btn = 9'h010; e.idx = 4'd4; e.lat = 18;
        exp_q.push_back(e);
        capture(b, idx, lat, w);
        e = exp_q.pop_front();
        checks++; if (b !== e.btn) begin failures++; $display("FAIL restart_btn got=%h exp=%h", b, e.btn); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL restart_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (idx !== e.idx) begin failures++; $display("FAIL restart_idx got=%0d exp=%0d", idx, e.idx); end
        @(negedge clk) p2_turn = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL restart_ack_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_game_over();
        test_timeout();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
